// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-8 stream demultiplexer.
package demux_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int N_OUT         = 8;
  localparam int SEL_W         = 3;
  localparam int CNT_W         = 16;

  typedef logic [N_OUT-1:0] out_vec_t;

  // One-hot decode of a destination select.
  function automatic out_vec_t sel_onehot(input logic [SEL_W-1:0] sel);
    out_vec_t v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// Single-entry output slot: holds one word and a full flag for one output.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_out_ready,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  // Load wins over drain, so a same-cycle drain+load leaves the slot full with new data.
  // The top only raises i_load when the slot is empty or draining.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (r_full && i_out_ready) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/demux8x8_stream.sv
// Valid/ready stream demultiplexer: one input routed to one of eight
// single-entry output slots, or broadcast to all eight, with a transfer counter.
module demux8x8_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [WIDTH-1:0] I,
  input  logic [SEL_W-1:0] S,
  input  logic             B,
  input  logic             I_valid,
  output logic             I_ready,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic [WIDTH-1:0] O4,
  output logic [WIDTH-1:0] O5,
  output logic [WIDTH-1:0] O6,
  output logic [WIDTH-1:0] O7,
  output logic [N_OUT-1:0] O_valid,
  input  logic [N_OUT-1:0] O_ready,
  output logic [CNT_W-1:0] CNT
);

  out_vec_t         w_full;
  out_vec_t         w_can_take;
  out_vec_t         w_load;
  logic             w_ready;
  logic             w_xfer;
  logic [WIDTH-1:0] w_data [N_OUT];
  logic [CNT_W-1:0] r_cnt;

  // Admission: unicast needs the selected slot free or draining, broadcast needs
  // every slot free or draining. Reset gates ready directly so nothing is
  // accepted while held, yet the first edge after release can already transfer.
  always_comb begin
    w_can_take = ~w_full | O_ready;
    w_ready    = B ? (&w_can_take) : w_can_take[S];
    I_ready    = ASYNCRESETN & w_ready;
    w_xfer     = I_valid & I_ready;
    w_load     = '0;
    if (w_xfer) begin
      w_load = B ? '1 : sel_onehot(S);
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .i_clk      (CLK),
      .i_rst_n    (ASYNCRESETN),
      .i_load     (w_load[k]),
      .i_data     (I),
      .i_out_ready(O_ready[k]),
      .o_full     (w_full[k]),
      .o_data     (w_data[k])
    );
  end

  // Accepted-transfer counter; a broadcast counts once, wraps naturally.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign O_valid = w_full;
  assign CNT     = r_cnt;
  assign O0      = w_data[0];
  assign O1      = w_data[1];
  assign O2      = w_data[2];
  assign O3      = w_data[3];
  assign O4      = w_data[4];
  assign O5      = w_data[5];
  assign O6      = w_data[6];
  assign O7      = w_data[7];

endmodule

// File: tb/tb_demux8x8_stream.sv
// Scoreboard bench for demux8x8_stream: accepted inputs push expected words per
// output, a negedge monitor pops and compares on every output handshake.
module tb_demux8x8_stream;

  logic       CLK = 1'b0;
  logic       ASYNCRESETN;
  logic [7:0] I;
  logic [2:0] S;
  logic       B;
  logic       I_valid;
  logic       I_ready;
  logic [7:0] o_dat [8];
  logic [7:0] O_valid;
  logic [7:0] O_ready;
  logic [15:0] CNT;

  logic [7:0] exp_q [8][$];
  int checks = 0;
  int errors = 0;

  demux8x8_stream #(.WIDTH(8)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .I(I), .S(S), .B(B), .I_valid(I_valid), .I_ready(I_ready),
    .O0(o_dat[0]), .O1(o_dat[1]), .O2(o_dat[2]), .O3(o_dat[3]),
    .O4(o_dat[4]), .O5(o_dat[5]), .O6(o_dat[6]), .O7(o_dat[7]),
    .O_valid(O_valid), .O_ready(O_ready), .CNT(CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 8; k++) exp_q[k].delete();
  endtask

  // Called at posedge+1 (or between edges); returns at posedge+1.
  task automatic send(input logic [7:0] d, input logic [2:0] s, input logic b,
                      input logic exp_rdy, input string name);
    logic acc;
    I = d; S = s; B = b; I_valid = 1'b1;
    @(negedge CLK);
    check({name, " ready"}, I_ready, exp_rdy);
    acc = I_ready;
    #1;
    if (acc) begin
      if (b) begin
        for (int k = 0; k < 8; k++) exp_q[k].push_back(d);
      end else begin
        exp_q[s].push_back(d);
      end
    end
    @(posedge CLK); #1;
    I_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Monitor: O_valid must mirror the model, every output handshake pops one word.
  always @(negedge CLK) begin
    logic [7:0] mv;
    logic [7:0] e;
    for (int k = 0; k < 8; k++) mv[k] = (exp_q[k].size() != 0);
    check("o_valid", O_valid, mv);
    for (int k = 0; k < 8; k++) begin
      if (O_valid[k] && O_ready[k]) begin
        if (exp_q[k].size() == 0) begin
          check($sformatf("o%0d unexpected", k), 32'd1, 32'd0);
        end else begin
          e = exp_q[k].pop_front();
          check($sformatf("o%0d data", k), o_dat[k], e);
        end
      end
    end
  end

  initial begin
    ASYNCRESETN = 1'b0;
    I = 8'h00; S = 3'd0; B = 1'b0; I_valid = 1'b1; O_ready = 8'h00;
    #2;
    check("rst ready", I_ready, 1'b0);
    check("rst valid", O_valid, 8'h00);
    check("rst cnt", CNT, 16'h0000);
    for (int k = 0; k < 8; k++) check($sformatf("rst o%0d", k), o_dat[k], 8'h00);
    I_valid = 1'b0;
    @(posedge CLK); #1;
    ASYNCRESETN = 1'b1;
    idle(1);

    // Unicast
    send(8'hA5, 3'd3, 1'b0, 1'b1, "uni");
    check("uni valid", O_valid, 8'h08);
    check("uni o3", o_dat[3], 8'hA5);
    check("uni cnt", CNT, 16'd1);

    // Backpressure on slot 3, then release
    send(8'h5A, 3'd3, 1'b0, 1'b0, "bp_block");
    check("bp o3 held", o_dat[3], 8'hA5);
    check("bp cnt", CNT, 16'd1);
    O_ready = 8'h08;
    send(8'h5A, 3'd3, 1'b0, 1'b1, "bp_drain");
    check("bp o3 new", o_dat[3], 8'h5A);
    check("bp valid", O_valid, 8'h08);
    check("bp cnt2", CNT, 16'd2);
    idle(1);
    O_ready = 8'h00;
    check("bp empty", O_valid, 8'h00);

    // Broadcast into empty slots
    send(8'h3C, 3'd6, 1'b1, 1'b1, "bc");
    check("bc valid", O_valid, 8'hFF);
    for (int k = 0; k < 8; k++) check($sformatf("bc o%0d", k), o_dat[k], 8'h3C);
    check("bc cnt", CNT, 16'd3);

    // Broadcast blocked by stalled slot 5; unicast to others still flows
    O_ready = 8'hDF;
    idle(1);
    O_ready = 8'h00;
    check("bcb valid", O_valid, 8'h20);
    send(8'h77, 3'd0, 1'b1, 1'b0, "bc_blk");
    check("bcb valid2", O_valid, 8'h20);
    check("bcb o5", o_dat[5], 8'h3C);
    check("bcb cnt", CNT, 16'd3);
    send(8'h99, 3'd2, 1'b0, 1'b1, "uni2");
    check("uni2 valid", O_valid, 8'h24);
    check("uni2 o2", o_dat[2], 8'h99);
    check("uni2 cnt", CNT, 16'd4);
    send(8'h11, 3'd5, 1'b0, 1'b0, "uni5_blk");
    check("uni5 o5", o_dat[5], 8'h3C);

    // Simultaneous drain and load
    O_ready = 8'hFF;
    send(8'hC3, 3'd1, 1'b1, 1'b1, "bc_drain");
    check("bcd valid", O_valid, 8'hFF);
    check("bcd o5", o_dat[5], 8'hC3);
    check("bcd cnt", CNT, 16'd5);
    send(8'hE1, 3'd6, 1'b0, 1'b1, "uni_thru");
    check("thru valid", O_valid, 8'h40);
    check("thru o6", o_dat[6], 8'hE1);
    check("thru cnt", CNT, 16'd6);
    idle(1);
    check("thru empty", O_valid, 8'h00);

    // Counter wrap after a fresh reset
    ASYNCRESETN = 1'b0;
    clear_model();
    idle(1);
    ASYNCRESETN = 1'b1;
    idle(1);
    O_ready = 8'hFF;
    for (int i = 0; i < 65535; i++) begin
      logic [31:0] iv;
      iv = i;
      send(iv[7:0], iv[2:0], 1'b0, 1'b1, "wrap");
    end
    check("cnt ffff", CNT, 16'hFFFF);
    send(8'h42, 3'd4, 1'b0, 1'b1, "wrap_last");
    check("cnt wrap", CNT, 16'h0000);
    idle(1);

    // Reset asserted mid-stream between edges
    O_ready = 8'h00;
    send(8'h12, 3'd1, 1'b0, 1'b1, "pre1");
    send(8'h34, 3'd4, 1'b0, 1'b1, "pre2");
    check("pre valid", O_valid, 8'h12);
    #2;
    ASYNCRESETN = 1'b0;
    clear_model();
    I = 8'hEE; S = 3'd0; B = 1'b0; I_valid = 1'b1;
    #1;
    check("mid valid", O_valid, 8'h00);
    check("mid cnt", CNT, 16'h0000);
    check("mid o1", o_dat[1], 8'h00);
    check("mid o4", o_dat[4], 8'h00);
    check("mid ready", I_ready, 1'b0);
    I_valid = 1'b0;
    @(posedge CLK); #2;
    ASYNCRESETN = 1'b1;
    send(8'h5F, 3'd7, 1'b0, 1'b1, "post_rst");
    check("post cnt", CNT, 16'd1);
    check("post valid", O_valid, 8'h80);
    check("post o7", o_dat[7], 8'h5F);
    O_ready = 8'hFF;
    idle(2);
    for (int k = 0; k < 8; k++) check($sformatf("q%0d leftover", k), exp_q[k].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
